ship_board_ctl: RTL

- Parametrised two-player battleship board store with a placement/battle state machine and a command/response handshake.
- Holds one BOARD_SIZE x BOARD_SIZE grid per player (host, guest) with 2-bit cell states.
- Enforces ship-count limits, rejects illegal moves, tracks hits and declares a winner.
- Sits between the mouse/UART command logic and the VGA board renderer; the renderer uses the registered read port.

---
 rtl/ship_board_ctl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ship_board_ctl.sv
// ship_board_ctl: two-player battleship board store.
// Handles placement, then battle, through a command/response handshake.
// It also provides a registered read port for the board renderer.
// Optional build macro: SHIP_ADJACENCY_CHECK_EN. When it is defined, a placement
// is refused if any neighbouring cell on the same board already holds a ship.
module ship_board_ctl #(
  parameter  int BOARD_SIZE = 9,
  parameter  int SHIPS      = 4,
  localparam int COORD_W    = $clog2(BOARD_SIZE),
  localparam int CNT_W      = $clog2(SHIPS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         start,
  input  logic               cmd_valid,
  input  logic [COORD_W-1:0] cmd_row,
  input  logic [COORD_W-1:0] cmd_col,
  output logic               cmd_ready,
  output logic               rsp_valid,
  output logic [1:0]         rsp_code,
  input  logic               rd_player,
  input  logic [COORD_W-1:0] rd_row,
  input  logic [COORD_W-1:0] rd_col,
  output logic [1:0]         rd_cell,
  output logic [CNT_W-1:0]   host_left,
  output logic [CNT_W-1:0]   guest_left,
  output logic               turn,
  output logic               game_over,
  output logic               winner
);

  typedef enum logic [2:0] {S_IDLE, S_PLACE_H, S_PLACE_G, S_BATTLE, S_OVER} state_e;

  localparam logic [1:0] C_EMPTY = 2'b00, C_SHIP = 2'b01, C_MISS = 2'b10, C_HIT = 2'b11;
  localparam logic [1:0] R_PLACED = 2'b00, R_MISS = 2'b01, R_HIT = 2'b10, R_REJ = 2'b11;

  state_e state_q, state_d;
  // Board index 0 is the host and index 1 is the guest. Each cell is a [row][col] pair of bits.
  logic [1:0][BOARD_SIZE-1:0][BOARD_SIZE-1:0][1:0] cells_q, cells_d;
  logic [1:0][CNT_W-1:0] left_q, left_d;
  logic       turn_q, turn_d, over_q, over_d, winner_q, winner_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [1:0] rsp_code_q, rsp_code_d, rd_cell_q, rd_cell_d;

  logic       accept, tgt, in_range, is_place, is_battle, adj, wr, dec, win;
  logic [1:0] cell_cur, new_cell, code;

  // Evaluate the command against the target board. The result is committed only on acceptance.
  always_comb begin
    accept    = cmd_valid && cmd_ready;
    is_place  = (state_q == S_PLACE_H) || (state_q == S_PLACE_G);
    is_battle = (state_q == S_BATTLE);
    // Placement writes the active player's own board. A shot writes the opponent's board.
    tgt       = is_battle ? ~turn_q : (state_q == S_PLACE_G);
    in_range  = (int'(cmd_row) < BOARD_SIZE) && (int'(cmd_col) < BOARD_SIZE);
    cell_cur  = C_EMPTY;
    adj       = 1'b0;
    for (int i = 0; i < BOARD_SIZE; i++)
      for (int j = 0; j < BOARD_SIZE; j++) begin
        if (int'(cmd_row) == i && int'(cmd_col) == j) cell_cur = cells_q[tgt][i][j];
`ifdef SHIP_ADJACENCY_CHECK_EN
        // The centre cell is included in this check. It is already rejected as occupied anyway.
        if (cells_q[tgt][i][j] == C_SHIP &&
            i >= int'(cmd_row) - 1 && i <= int'(cmd_row) + 1 &&
            j >= int'(cmd_col) - 1 && j <= int'(cmd_col) + 1) adj = 1'b1;
`endif
      end
    code     = R_REJ;
    new_cell = cell_cur;
    wr       = 1'b0;
    dec      = 1'b0;
    if (is_place) begin
      if (in_range && cell_cur == C_EMPTY && left_q[tgt] != '0 && !adj) begin
        code = R_PLACED; new_cell = C_SHIP; wr = 1'b1; dec = 1'b1;
      end
    end else if (is_battle && in_range) begin
      if (cell_cur == C_EMPTY) begin
        code = R_MISS; new_cell = C_MISS; wr = 1'b1;
      end else if (cell_cur == C_SHIP) begin
        code = R_HIT; new_cell = C_HIT; wr = 1'b1; dec = 1'b1;
      end
    end
    win = accept && is_battle && dec && (left_q[tgt] == CNT_W'(1));
  end

  // Phase sequencing. Start requests are ignored while a response is being presented.
  always_comb begin
    state_d = state_q;
    if (!rsp_valid_q) begin
      case (state_q)
        S_IDLE:    if (start == 2'b01) state_d = S_PLACE_H;
        S_PLACE_H: if (start == 2'b10 && left_q[0] == '0) state_d = S_PLACE_G;
        S_PLACE_G: if (start == 2'b11 && left_q[1] == '0) state_d = S_BATTLE;
        S_BATTLE:  if (win) state_d = S_OVER;
        default:   state_d = state_q;
      endcase
    end
  end

  // Handshake output. The block is busy during the response cycle, so commands are spaced out.
  always_comb begin
    cmd_ready = ((state_q == S_PLACE_H) || (state_q == S_PLACE_G) || (state_q == S_BATTLE))
                && !rsp_valid_q;
  end

  // Next values for the board, counters, turn and result flags.
  always_comb begin
    cells_d     = cells_q;
    left_d      = left_q;
    turn_d      = turn_q;
    over_d      = over_q;
    winner_d    = winner_q;
    rsp_valid_d = accept;
    rsp_code_d  = accept ? code : rsp_code_q;
    if (accept && wr)
      for (int i = 0; i < BOARD_SIZE; i++)
        for (int j = 0; j < BOARD_SIZE; j++)
          if (int'(cmd_row) == i && int'(cmd_col) == j) cells_d[tgt][i][j] = new_cell;
    if (accept && dec) left_d[tgt] = left_q[tgt] - CNT_W'(1);
    if (accept && is_battle && wr) turn_d = ~turn_q;
    if (win) begin
      over_d   = 1'b1;
      winner_d = turn_q;
    end
    // During placement the counters count down the cells still to place.
    // When battle starts they are reloaded to count unhit ship cells.
    if (state_q == S_PLACE_G && state_d == S_BATTLE) begin
      left_d[0] = CNT_W'(SHIPS);
      left_d[1] = CNT_W'(SHIPS);
    end
  end

  // Registered read port. It samples the pre-write contents, and out-of-range reads return 00.
  always_comb begin
    rd_cell_d = C_EMPTY;
    for (int i = 0; i < BOARD_SIZE; i++)
      for (int j = 0; j < BOARD_SIZE; j++)
        if (int'(rd_row) == i && int'(rd_col) == j) rd_cell_d = cells_q[rd_player][i][j];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers. An asynchronous reset drops any pending response and any board contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells_q     <= '0;
      left_q      <= {CNT_W'(SHIPS), CNT_W'(SHIPS)};
      turn_q      <= 1'b0;
      over_q      <= 1'b0;
      winner_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= 2'b00;
      rd_cell_q   <= 2'b00;
    end else begin
      cells_q     <= cells_d;
      left_q      <= left_d;
      turn_q      <= turn_d;
      over_q      <= over_d;
      winner_q    <= winner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      rd_cell_q   <= rd_cell_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_code   = rsp_code_q;
  assign rd_cell    = rd_cell_q;
  assign host_left  = left_q[0];
  assign guest_left = left_q[1];
  assign turn       = turn_q;
  assign game_over  = over_q;
  assign winner     = winner_q;

endmodule
